// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the X/Y working-register datapath and its sequencer:
//   - 3-bit register function codes (CLEAR/LOAD/HOLD/SL/SR)
//   - 3-bit instruction opcodes
//   - 2-bit Y load-source select codes
//   - sequencer FSM state codes
//   - cmd_t bundle plus a decoder for the single-cycle instructions
// No ports (package).
// ---------------------------------------------------------------------------
package calc_pkg;

    // Register function codes
    localparam logic [2:0] FUNC_CLEAR = 3'b000;
    localparam logic [2:0] FUNC_LOAD  = 3'b001;
    localparam logic [2:0] FUNC_HOLD  = 3'b010;
    localparam logic [2:0] FUNC_SL    = 3'b011;
    localparam logic [2:0] FUNC_SR    = 3'b100;

    // Instruction opcodes
    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDX = 3'b001;
    localparam logic [2:0] OP_LDY = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_CLR = 3'b111;

    // Y load-source select
    localparam logic [1:0] YSEL_EXT = 2'b00;
    localparam logic [1:0] YSEL_X   = 2'b01;
    localparam logic [1:0] YSEL_ALU = 2'b10;

    // Sequencer FSM states
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_EXEC  = 2'b01;
    localparam logic [1:0] ST_SHIFT = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    // Everything the sequencer drives towards the registers in one cycle
    typedef struct packed {
        logic [2:0] func_x;
        logic [2:0] func_y;
        logic [1:0] y_sel;
    } cmd_t;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SHL) || (op == OP_SHR);
    endfunction

    // Single-cycle decode. Shifts reach this only with a zero count, in
    // which case they behave like NOP and leave both registers alone.
    function automatic cmd_t decode_op(input logic [2:0] op);
        cmd_t c;
        c.func_x = FUNC_HOLD;
        c.func_y = FUNC_HOLD;
        c.y_sel  = YSEL_EXT;
        case (op)
            OP_LDX: c.func_x = FUNC_LOAD;
            OP_LDY: c.func_y = FUNC_LOAD;
            OP_ADD: begin
                c.func_y = FUNC_LOAD;
                c.y_sel  = YSEL_ALU;
            end
            OP_MOV: begin
                c.func_y = FUNC_LOAD;
                c.y_sel  = YSEL_X;
            end
            OP_CLR: begin
                c.func_x = FUNC_CLEAR;
                c.func_y = FUNC_CLEAR;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/shift_counter.sv
// ---------------------------------------------------------------------------
// shift_counter
// Loadable down-counter that tracks how many shift cycles remain.
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset (count -> 0)
//   load       - load load_value (takes priority over dec)
//   load_value - new count
//   dec        - decrement by one; saturates at zero
//   last       - high while count == 1, i.e. the current shift is the final one
// ---------------------------------------------------------------------------
module shift_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             last
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == WIDTH'(1));

endmodule

// File: rtl/register_sequencer.sv
// ---------------------------------------------------------------------------
// register_sequencer
// Accepts one instruction at a time and expands it into per-cycle function
// codes for the 4-bit X/Y working registers, plus the Y load-source select.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready - instruction handshake (accepted on valid & ready)
//   cmd_op, cmd_amt     - opcode and shift amount (amount clamped to SHIFT_MAX)
//   func_x, func_y      - function codes to registers X and Y
//   y_sel               - Y load source (00 ext, 01 X, 10 ALU)
//   done                - one-cycle pulse as an instruction completes
// All outputs are Moore: decoded from state and the latched opcode only.
// ---------------------------------------------------------------------------
module register_sequencer
    import calc_pkg::*;
#(
    parameter int SHIFT_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [2:0] cmd_amt,
    output logic [2:0] func_x,
    output logic [2:0] func_y,
    output logic [1:0] y_sel,
    output logic       done
);

    localparam int CW = $clog2(SHIFT_MAX + 1);

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [2:0]    op_q;
    logic [CW+2:0] amt_wide;
    logic [CW-1:0] amt_clamped;
    logic          accept;
    logic          go_shift;
    logic          last;
    cmd_t          cmd;

    // Widen before comparing so the clamp is correct whichever of the
    // counter width and the 3-bit amount field is larger.
    assign amt_wide    = (CW+3)'(cmd_amt);
    assign amt_clamped = (amt_wide > (CW+3)'(SHIFT_MAX)) ? CW'(SHIFT_MAX)
                                                          : CW'(cmd_amt);

    assign accept   = cmd_valid && (state == ST_IDLE);
    assign go_shift = is_shift(cmd_op) && (amt_clamped != '0);

    shift_counter #(
        .WIDTH(CW)
    ) u_shift_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept && go_shift),
        .load_value(amt_clamped),
        .dec       (state == ST_SHIFT),
        .last      (last)
    );

    // Next-state logic. A zero-count shift takes the EXEC path so every
    // instruction still produces exactly one done pulse.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept) state_next = go_shift ? ST_SHIFT : ST_EXEC;
            ST_EXEC:  state_next = ST_DONE;
            ST_SHIFT: if (last) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State and latched opcode; cmd_* is ignored except at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op_q  <= OP_NOP;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q <= cmd_op;
            end
        end
    end

    // Output decode; every state other than EXEC/SHIFT holds both registers.
    always_comb begin
        cmd.func_x = FUNC_HOLD;
        cmd.func_y = FUNC_HOLD;
        cmd.y_sel  = YSEL_EXT;
        if (state == ST_EXEC) begin
            cmd = decode_op(op_q);
        end else if (state == ST_SHIFT) begin
            cmd.func_y = (op_q == OP_SHR) ? FUNC_SR : FUNC_SL;
        end
    end

    assign func_x    = cmd.func_x;
    assign func_y    = cmd.func_y;
    assign y_sel     = cmd.y_sel;
    assign done      = (state == ST_DONE);
    assign cmd_ready = (state == ST_IDLE);

endmodule

// File: tb/tb_register_sequencer.sv
// ---------------------------------------------------------------------------
// tb_register_sequencer
// Self-checking bench for register_sequencer: a table of single instructions,
// hand-written multi-cycle sequences, and a randomized run checked against a
// queue-based transaction model.
// ---------------------------------------------------------------------------
module tb_register_sequencer;

    localparam int SHIFT_MAX = 4;

    localparam logic [2:0] F_CLEAR = 3'd0;
    localparam logic [2:0] F_LOAD  = 3'd1;
    localparam logic [2:0] F_HOLD  = 3'd2;
    localparam logic [2:0] F_SL    = 3'd3;
    localparam logic [2:0] F_SR    = 3'd4;

    localparam logic [2:0] O_NOP = 3'd0;
    localparam logic [2:0] O_LDX = 3'd1;
    localparam logic [2:0] O_LDY = 3'd2;
    localparam logic [2:0] O_ADD = 3'd3;
    localparam logic [2:0] O_SHL = 3'd4;
    localparam logic [2:0] O_SHR = 3'd5;
    localparam logic [2:0] O_MOV = 3'd6;
    localparam logic [2:0] O_CLR = 3'd7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [2:0] cmd_amt;
    logic [2:0] func_x;
    logic [2:0] func_y;
    logic [1:0] y_sel;
    logic       done;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [2:0] op;
        logic [2:0] amt;
        logic [2:0] fx;
        logic [2:0] fy;
        logic [1:0] ys;
        int         done_at;
        int         active;
    } vec_t;

    typedef struct packed {
        logic [2:0] fx;
        logic [2:0] fy;
        logic [1:0] ys;
        logic       dn;
        logic       rdy;
    } obs_t;

    vec_t vecs[11];
    obs_t exp_q[$];

    register_sequencer #(
        .SHIFT_MAX(SHIFT_MAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_amt  (cmd_amt),
        .func_x   (func_x),
        .func_y   (func_y),
        .y_sel    (y_sel),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [2:0] amt);
        cmd_valid = v;
        cmd_op    = op;
        cmd_amt   = amt;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, O_NOP, 3'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issue one instruction from idle and follow it to its done pulse
    task automatic runVector(input int idx, input vec_t v);
        int k;
        int act;
        checkOutput($sformatf("v%0d_ready_before", idx), 32'(cmd_ready), 32'd1);
        applyStimulus(1'b1, v.op, v.amt);
        @(negedge clk);
        applyStimulus(1'b0, 3'($urandom), 3'($urandom));
        checkOutput($sformatf("v%0d_first_fx", idx), 32'(func_x), 32'(v.fx));
        checkOutput($sformatf("v%0d_first_fy", idx), 32'(func_y), 32'(v.fy));
        checkOutput($sformatf("v%0d_first_ysel", idx), 32'(y_sel), 32'(v.ys));
        k   = 1;
        act = 0;
        while (done !== 1'b1 && k < 12) begin
            if (func_x !== F_HOLD || func_y !== F_HOLD) act++;
            @(negedge clk);
            k++;
        end
        checkOutput($sformatf("v%0d_done_at", idx), 32'(k), 32'(v.done_at));
        checkOutput($sformatf("v%0d_active_cycles", idx), 32'(act), 32'(v.active));
        checkOutput($sformatf("v%0d_done_fy", idx), 32'(func_y), 32'(F_HOLD));
        @(negedge clk);
        checkOutput($sformatf("v%0d_ready_after", idx), 32'(cmd_ready), 32'd1);
        checkOutput($sformatf("v%0d_done_width", idx), 32'(done), 32'd0);
    endtask

    // Run a shift while a 4-bit Y register model follows func_y
    task automatic runShift(input string name, input logic [2:0] op, input logic [2:0] amt,
                            input logic [2:0] exp_func, input int exp_count, input int exp_done,
                            input logic [3:0] y_in, output logic [3:0] y_out);
        int cnt;
        int done_at;
        logic [3:0] y;
        y       = y_in;
        cnt     = 0;
        done_at = 0;
        applyStimulus(1'b1, op, amt);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) applyStimulus(1'b0, O_NOP, 3'd0);
            if (func_y === F_SL) y = {y[2:0], 1'b0};
            else if (func_y === F_SR) y = {1'b0, y[3:1]};
            if (func_y === exp_func) cnt++;
            if (done === 1'b1 && done_at == 0) done_at = k;
        end
        checkOutput({name, "_shift_cycles"}, 32'(cnt), 32'(exp_count));
        checkOutput({name, "_done_at"}, 32'(done_at), 32'(exp_done));
        y_out = y;
    endtask

    // Reference model: an accepted instruction becomes the list of
    // per-cycle observations it should produce, ending in its done cycle.
    task automatic pushExpansion(input logic [2:0] op, input logic [2:0] amt);
        int   n;
        obs_t r;
        n = (int'(amt) > SHIFT_MAX) ? SHIFT_MAX : int'(amt);
        if ((op == O_SHL || op == O_SHR) && n > 0) begin
            for (int i = 0; i < n; i++)
                exp_q.push_back({F_HOLD, (op == O_SHL) ? F_SL : F_SR, 2'b00, 1'b0, 1'b0});
        end else begin
            case (op)
                O_LDX:   r = {F_LOAD,  F_HOLD,  2'b00, 1'b0, 1'b0};
                O_LDY:   r = {F_HOLD,  F_LOAD,  2'b00, 1'b0, 1'b0};
                O_ADD:   r = {F_HOLD,  F_LOAD,  2'b10, 1'b0, 1'b0};
                O_MOV:   r = {F_HOLD,  F_LOAD,  2'b01, 1'b0, 1'b0};
                O_CLR:   r = {F_CLEAR, F_CLEAR, 2'b00, 1'b0, 1'b0};
                default: r = {F_HOLD,  F_HOLD,  2'b00, 1'b0, 1'b0};
            endcase
            exp_q.push_back(r);
        end
        exp_q.push_back({F_HOLD, F_HOLD, 2'b00, 1'b1, 1'b0});
    endtask

    initial begin
        int         ldx_cnt;
        int         ldy_at;
        int         done_cnt;
        logic [1:0] ldy_ys;
        logic       rdy3;
        logic [3:0] y1;
        logic [3:0] y2;
        obs_t       e;
        obs_t       a;
        logic       v;
        logic       acc;
        logic [2:0] op;
        logic [2:0] amt;

        // Asynchronous reset state, checked before any clock edge
        rst_n = 1'b0;
        applyStimulus(1'b0, O_NOP, 3'd0);
        #1;
        checkOutput("reset_ready", 32'(cmd_ready), 32'd1);
        checkOutput("reset_fx", 32'(func_x), 32'(F_HOLD));
        checkOutput("reset_fy", 32'(func_y), 32'(F_HOLD));
        checkOutput("reset_ysel", 32'(y_sel), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        //          op     amt   fx       fy       ys     done act
        vecs[0]  = '{O_NOP, 3'd5, F_HOLD,  F_HOLD,  2'b00, 2,   0};
        vecs[1]  = '{O_LDX, 3'd0, F_LOAD,  F_HOLD,  2'b00, 2,   1};
        vecs[2]  = '{O_LDY, 3'd2, F_HOLD,  F_LOAD,  2'b00, 2,   1};
        vecs[3]  = '{O_ADD, 3'd0, F_HOLD,  F_LOAD,  2'b10, 2,   1};
        vecs[4]  = '{O_SHL, 3'd3, F_HOLD,  F_SL,    2'b00, 4,   3};
        vecs[5]  = '{O_SHR, 3'd7, F_HOLD,  F_SR,    2'b00, 5,   4};
        vecs[6]  = '{O_SHR, 3'd0, F_HOLD,  F_HOLD,  2'b00, 2,   0};
        vecs[7]  = '{O_MOV, 3'd1, F_HOLD,  F_LOAD,  2'b01, 2,   1};
        vecs[8]  = '{O_CLR, 3'd0, F_CLEAR, F_CLEAR, 2'b00, 2,   1};
        vecs[9]  = '{O_SHL, 3'd1, F_HOLD,  F_SL,    2'b00, 2,   1};
        vecs[10] = '{O_SHL, 3'd5, F_HOLD,  F_SL,    2'b00, 5,   4};
        for (int i = 0; i < 11; i++) runVector(i, vecs[i]);

        // LDX then LDY with valid held high; op change while busy ignored
        ldx_cnt = 0; ldy_at = 0; done_cnt = 0; ldy_ys = 2'b11; rdy3 = 1'b0;
        applyStimulus(1'b1, O_LDX, 3'd0);
        for (int t = 1; t <= 7; t++) begin
            @(negedge clk);
            if (t == 1) applyStimulus(1'b1, O_LDY, 3'd0);
            if (t == 4) applyStimulus(1'b0, O_NOP, 3'd0);
            if (func_x === F_LOAD) ldx_cnt++;
            if (func_y === F_LOAD && ldy_at == 0) begin
                ldy_at = t;
                ldy_ys = y_sel;
            end
            if (done === 1'b1) done_cnt++;
            if (t == 3) rdy3 = cmd_ready;
        end
        checkOutput("b2b_ldx_cycles", 32'(ldx_cnt), 32'd1);
        checkOutput("b2b_ldy_cycle", 32'(ldy_at), 32'd4);
        checkOutput("b2b_ldy_ysel", 32'(ldy_ys), 32'd0);
        checkOutput("b2b_done_pulses", 32'(done_cnt), 32'd2);
        checkOutput("b2b_ready_cycle3", 32'(rdy3), 32'd1);

        // Shifts against a Y register model
        runShift("shl3", O_SHL, 3'd3, F_SL, 3, 4, 4'b0001, y1);
        checkOutput("shl3_y", 32'(y1), 32'h8);
        runShift("shr7", O_SHR, 3'd7, F_SR, 4, 5, y1, y2);
        checkOutput("shr7_y", 32'(y2), 32'h0);

        // Reset asserted mid-shift
        applyStimulus(1'b1, O_SHL, 3'd3);
        @(negedge clk);
        applyStimulus(1'b0, O_NOP, 3'd0);
        checkOutput("rstmid_sl", 32'(func_y), 32'(F_SL));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_fy_hold", 32'(func_y), 32'(F_HOLD));
        checkOutput("rstmid_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rstmid_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int t = 0; t < 6; t++) begin
            if (done === 1'b1 || func_y !== F_HOLD) done_cnt++;
            @(negedge clk);
        end
        checkOutput("rstmid_no_activity", 32'(done_cnt), 32'd0);

        // Randomized run against the transaction model
        doReset();
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            e = (exp_q.size() > 0) ? exp_q[0] : obs_t'({F_HOLD, F_HOLD, 2'b00, 1'b0, 1'b1});
            a = {func_x, func_y, y_sel, done, cmd_ready};
            checkOutput($sformatf("rand_cycle%0d", c), 32'(a), 32'(e));
            v   = ($urandom_range(0, 2) != 0);
            op  = 3'($urandom);
            amt = 3'($urandom);
            applyStimulus(v, op, amt);
            acc = (exp_q.size() == 0) && v;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc) pushExpansion(op, amt);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
